snoopy_invalidate_controller: RTL and testbench

- Snoop-side controller of the invalidate-protocol (MSI) snoopy cache.
- Sits directly downstream of the cache's concurrency lock and consumes its snoopy command stream (commandIn) and snoopy read-memory port.
- For each bus command, it updates the local line state, flushes a MODIFIED line word by word onto the bus, and signals completion to the bus via isInvalidated.

---
 rtl/snoopy_invalidate_controller_pkg.sv | 36 +++
 rtl/snoopy_invalidate_controller_if.sv | 37 +++
 rtl/snoopy_invalidate_controller_line_flush_sequencer.sv | 77 +++++++
 rtl/snoopy_invalidate_controller.sv | 121 ++++++++++++
 tb/tb_snoopy_invalidate_controller.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/snoopy_invalidate_controller_pkg.sv
// Shared types for the MSI snoop controller: bus commands, line states and FSM encodings.
package snoopy_invalidate_controller_pkg;

   typedef enum logic [1:0] {
      NONE               = 2'd0,
      BUS_READ           = 2'd1,
      BUS_READ_EXCLUSIVE = 2'd2,
      BUS_INVALIDATE     = 2'd3
   } command_t;

   typedef enum logic [1:0] {
      INVALID  = 2'd0,
      SHARED   = 2'd1,
      MODIFIED = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      EVALUATE     = 3'd1,
      FLUSH_LINE   = 3'd2,
      UPDATE_STATE = 3'd3,
      DONE         = 3'd4
   } snoop_fsm_t;

   typedef enum logic [1:0] {
      SEQ_IDLE   = 2'd0,
      READ_WORD  = 2'd1,
      FLUSH_WORD = 2'd2
   } flush_fsm_t;

   // A flushed line stays readable locally only when the other cache merely reads it.
   function automatic state_t flush_target(input command_t cmd);
      return (cmd == BUS_READ) ? SHARED : INVALID;
   endfunction

endpackage

// File: rtl/snoopy_invalidate_controller_if.sv
// Snoop command, cache read port and bus flush signals of the snoop controller.
interface snoopy_invalidate_controller_if
   import snoopy_invalidate_controller_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32
);
   command_t                 commandIn;
   logic [ADDRESS_WIDTH-1:0] snoopyAddress;
   logic                     snoopyHit;
   state_t                   stateIn;
   logic                     isInvalidated;
   state_t                   stateOut;
   logic                     writeState;
   logic [ADDRESS_WIDTH-1:0] readAddress;
   logic                     readEnabled;
   logic [DATA_WIDTH-1:0]    readDataIn;
   logic                     readFunctionComplete;
   logic [DATA_WIDTH-1:0]    busDataOut;
   logic                     busFlush;
   logic                     busAck;
   logic                     protocolError;

   modport slave (
      input  commandIn, snoopyAddress, snoopyHit, stateIn,
      input  readDataIn, readFunctionComplete, busAck,
      output isInvalidated, stateOut, writeState, readAddress, readEnabled,
      output busDataOut, busFlush, protocolError
   );

   modport master (
      output commandIn, snoopyAddress, snoopyHit, stateIn,
      output readDataIn, readFunctionComplete, busAck,
      input  isInvalidated, stateOut, writeState, readAddress, readEnabled,
      input  busDataOut, busFlush, protocolError
   );
endinterface

// File: rtl/snoopy_invalidate_controller_line_flush_sequencer.sv
// Streams one cache line to the bus: read a word, hold it on the bus until acknowledged, repeat.
module snoopy_invalidate_controller_line_flush_sequencer
   import snoopy_invalidate_controller_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int OFFSET_WIDTH  = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     start_i,
   input  logic [ADDRESS_WIDTH-1:0] base_i,
   output logic                     done_o,
   output logic [ADDRESS_WIDTH-1:0] readAddress_o,
   output logic                     readEnabled_o,
   input  logic [DATA_WIDTH-1:0]    readDataIn_i,
   input  logic                     readFunctionComplete_i,
   output logic [DATA_WIDTH-1:0]    busDataOut_o,
   output logic                     busFlush_o,
   input  logic                     busAck_i
);
   flush_fsm_t              state_q, state_d;
   logic [OFFSET_WIDTH-1:0] count_q, count_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= SEQ_IDLE;
         count_q <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      data_d  = data_q;
      done_o  = 1'b0;
      case (state_q)
         SEQ_IDLE: begin
            if (start_i) begin
               count_d = '0;
               state_d = READ_WORD;
            end
         end
         READ_WORD: begin
            if (readFunctionComplete_i) begin
               data_d  = readDataIn_i;
               state_d = FLUSH_WORD;
            end
         end
         FLUSH_WORD: begin
            // Last-word test precedes the increment so the counter never leaves the line.
            if (busAck_i) begin
               if (count_q == '1) begin
                  done_o  = 1'b1;
                  state_d = SEQ_IDLE;
               end else begin
                  count_d = count_q + OFFSET_WIDTH'(1);
                  state_d = READ_WORD;
               end
            end
         end
         default: state_d = SEQ_IDLE;
      endcase
   end

   assign readEnabled_o = (state_q == READ_WORD);
   assign busFlush_o    = (state_q == FLUSH_WORD);
   assign readAddress_o = base_i | ADDRESS_WIDTH'(count_q);
   assign busDataOut_o  = data_q;

endmodule

// File: rtl/snoopy_invalidate_controller.sv
// Snoop-side controller of an MSI snoopy cache: evaluates each bus command against the hit
// line, flushes MODIFIED lines through the sequencer and writes back the new line state.
module snoopy_invalidate_controller
   import snoopy_invalidate_controller_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int OFFSET_WIDTH  = 4
) (
   input  logic clock,
   input  logic reset,
   snoopy_invalidate_controller_if.slave bus_io
);
   localparam logic [ADDRESS_WIDTH-1:0] OFFSET_MASK =
      {{(ADDRESS_WIDTH-OFFSET_WIDTH){1'b0}}, {OFFSET_WIDTH{1'b1}}};

   snoop_fsm_t               state_q, state_d;
   command_t                 cmd_q;
   logic [ADDRESS_WIDTH-1:0] base_q;
   logic                     hit_q;
   state_t                   line_q;
   state_t                   new_state_q, new_state_d;
   logic                     error_q, error_d;
   logic                     accept;
   logic                     flush_start;
   logic                     flush_done;

   assign accept = (state_q == IDLE) && (bus_io.commandIn != NONE);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cmd_q       <= NONE;
         base_q      <= '0;
         hit_q       <= 1'b0;
         line_q      <= INVALID;
         new_state_q <= INVALID;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         new_state_q <= new_state_d;
         error_q     <= error_d;
         if (accept) begin
            cmd_q  <= bus_io.commandIn;
            base_q <= bus_io.snoopyAddress & ~OFFSET_MASK;
            hit_q  <= bus_io.snoopyHit;
            line_q <= bus_io.stateIn;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      new_state_d = new_state_q;
      error_d     = error_q;
      flush_start = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) state_d = EVALUATE;
         end
         EVALUATE: begin
            if (!hit_q || line_q == INVALID) begin
               state_d = DONE;
            end else if (line_q == SHARED) begin
               if (cmd_q == BUS_READ) begin
                  state_d = DONE;
               end else begin
                  new_state_d = INVALID;
                  state_d     = UPDATE_STATE;
               end
            end else if (line_q == MODIFIED) begin
               // Another cache claiming to invalidate a line we own dirty means the bus is broken.
               if (cmd_q == BUS_INVALIDATE) begin
                  error_d     = 1'b1;
                  new_state_d = INVALID;
                  state_d     = UPDATE_STATE;
               end else begin
                  new_state_d = flush_target(cmd_q);
                  flush_start = 1'b1;
                  state_d     = FLUSH_LINE;
               end
            end else begin
               state_d = DONE;
            end
         end
         FLUSH_LINE: begin
            if (flush_done) state_d = UPDATE_STATE;
         end
         UPDATE_STATE: state_d = DONE;
         DONE: begin
            if (bus_io.commandIn == NONE) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   snoopy_invalidate_controller_line_flush_sequencer #(
      .ADDRESS_WIDTH (ADDRESS_WIDTH),
      .DATA_WIDTH    (DATA_WIDTH),
      .OFFSET_WIDTH  (OFFSET_WIDTH)
   ) u_flush (
      .clock                  (clock),
      .reset                  (reset),
      .start_i                (flush_start),
      .base_i                 (base_q),
      .done_o                 (flush_done),
      .readAddress_o          (bus_io.readAddress),
      .readEnabled_o          (bus_io.readEnabled),
      .readDataIn_i           (bus_io.readDataIn),
      .readFunctionComplete_i (bus_io.readFunctionComplete),
      .busDataOut_o           (bus_io.busDataOut),
      .busFlush_o             (bus_io.busFlush),
      .busAck_i               (bus_io.busAck)
   );

   assign bus_io.isInvalidated = (state_q == DONE);
   assign bus_io.writeState    = (state_q == UPDATE_STATE);
   assign bus_io.stateOut      = new_state_q;
   assign bus_io.protocolError = error_q;

endmodule

// File: tb/tb_snoopy_invalidate_controller.sv
// Randomized bench for the snoop controller, checked against a transaction-level MSI model.
module tb_snoopy_invalidate_controller
   import snoopy_invalidate_controller_pkg::*;
;
   logic clock;
   logic reset;

   snoopy_invalidate_controller_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) sif ();

   snoopy_invalidate_controller #(
      .ADDRESS_WIDTH (32),
      .DATA_WIDTH    (32),
      .OFFSET_WIDTH  (4)
   ) dut (
      .clock  (clock),
      .reset  (reset),
      .bus_io (sif)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int          n_checks;
   int          n_fail;
   logic [31:0] exp_addr_q[$];
   logic [31:0] exp_data_q[$];
   logic [31:0] obs_addr[$];
   logic [31:0] obs_data[$];
   bit          exp_ws;
   state_t      exp_state;
   state_t      last_ws_state;
   int          ws_count;
   bit          model_err;
   bit          txn_active;
   bit          data_idx_mode;
   int          rd_plan[16];
   int          ack_plan[16];
   int          rd_idx;
   int          ack_idx;
   int          wait_sum;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   task automatic fail_now(input string name, input logic [63:0] act);
      n_checks++;
      n_fail++;
      $display("FAIL %s: observed 0x%0h (t=%0t)", name, act, $time);
   endtask

   // Bench memory: word index mode for the literal tests, a scrambled pattern otherwise.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return data_idx_mode ? {28'd0, a[3:0]} : ((a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F);
   endfunction

   initial begin : cache_responder
      int  wait_left;
      bit  busy;
      busy = 0;
      wait_left = 0;
      sif.readFunctionComplete = 1'b0;
      sif.readDataIn = '0;
      forever begin
         @(negedge clock);
         sif.readFunctionComplete = 1'b0;
         sif.readDataIn = $urandom;
         if (reset) begin
            busy = 0;
         end else if (sif.readEnabled) begin
            if (!busy) begin
               busy = 1;
               wait_left = rd_plan[rd_idx & 15];
            end
            if (wait_left == 0) begin
               sif.readFunctionComplete = 1'b1;
               sif.readDataIn = mem_word(sif.readAddress);
               busy = 0;
               rd_idx++;
            end else begin
               wait_left--;
               wait_sum++;
            end
         end else begin
            sif.readFunctionComplete = ($urandom_range(0, 3) == 0);
         end
      end
   end

   initial begin : bus_responder
      int  wait_left;
      bit  busy;
      busy = 0;
      wait_left = 0;
      sif.busAck = 1'b0;
      forever begin
         @(negedge clock);
         sif.busAck = 1'b0;
         if (reset) begin
            busy = 0;
         end else if (sif.busFlush) begin
            if (!busy) begin
               busy = 1;
               wait_left = ack_plan[ack_idx & 15];
            end
            if (wait_left == 0) begin
               sif.busAck = 1'b1;
               busy = 0;
               ack_idx++;
            end else begin
               wait_left--;
               wait_sum++;
            end
         end else begin
            sif.busAck = ($urandom_range(0, 3) == 0);
         end
      end
   end

   initial begin : compare
      bit          prev_re;
      bit          prev_bf;
      logic [31:0] held_a;
      logic [31:0] held_d;
      prev_re = 0;
      prev_bf = 0;
      held_a = '0;
      held_d = '0;
      forever begin
         @(negedge clock);
         if (reset) begin
            prev_re = 0;
            prev_bf = 0;
         end else begin
            if (!txn_active) begin
               check("idle_outputs", {sif.isInvalidated, sif.writeState, sif.readEnabled, sif.busFlush}, 4'b0);
               check("idle_protocolError", sif.protocolError, model_err);
            end else begin
               check("read_and_flush_exclusive", sif.readEnabled & sif.busFlush, 1'b0);
               if (model_err) check("protocolError_sticky", sif.protocolError, 1'b1);
               if (sif.readEnabled) begin
                  if (!prev_re) begin
                     if (exp_addr_q.size() == 0) fail_now("unexpected_read", sif.readAddress);
                     else check("readAddress", sif.readAddress, exp_addr_q.pop_front());
                     obs_addr.push_back(sif.readAddress);
                     held_a = sif.readAddress;
                  end else begin
                     check("readAddress_stable", sif.readAddress, held_a);
                  end
               end
               if (sif.busFlush) begin
                  if (!prev_bf) begin
                     if (exp_data_q.size() == 0) fail_now("unexpected_flush", sif.busDataOut);
                     else check("busDataOut", sif.busDataOut, exp_data_q.pop_front());
                     obs_data.push_back(sif.busDataOut);
                     held_d = sif.busDataOut;
                  end else begin
                     check("busDataOut_stable", sif.busDataOut, held_d);
                  end
               end
               if (sif.writeState) begin
                  ws_count++;
                  last_ws_state = sif.stateOut;
                  if (!exp_ws) fail_now("unexpected_writeState", sif.stateOut);
                  else check("stateOut", sif.stateOut, exp_state);
               end
            end
            prev_re = sif.readEnabled;
            prev_bf = sif.busFlush;
         end
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_flags"}, {sif.isInvalidated, sif.writeState, sif.readEnabled,
                              sif.busFlush, sif.protocolError}, 5'b0);
      check({tag, "_readAddress"}, sif.readAddress, 32'h0);
      check({tag, "_busDataOut"}, sif.busDataOut, 32'h0);
      check({tag, "_stateOut"}, sif.stateOut, INVALID);
   endtask

   task automatic run_txn(input command_t cmd, input logic [31:0] addr, input logic hit,
                          input state_t st, input int wait_max, input int slow_word,
                          input int reset_word, output int lat);
      logic [31:0] base;
      bit          flush;
      bit          new_err;
      int          exp_lat;
      base    = addr & 32'hFFFF_FFF0;
      flush   = hit && st == MODIFIED && cmd != BUS_INVALIDATE;
      new_err = hit && st == MODIFIED && cmd == BUS_INVALIDATE;
      exp_ws  = hit && (st == MODIFIED || (st == SHARED && cmd != BUS_READ));
      exp_state = (flush && cmd == BUS_READ) ? SHARED : INVALID;
      last_ws_state = MODIFIED;
      exp_addr_q.delete();
      exp_data_q.delete();
      obs_addr.delete();
      obs_data.delete();
      for (int i = 0; i < 16; i++) begin
         rd_plan[i]  = int'($urandom_range(0, wait_max));
         ack_plan[i] = (i == slow_word) ? 3 : int'($urandom_range(0, wait_max));
         if (flush) begin
            exp_addr_q.push_back(base | i);
            exp_data_q.push_back(mem_word(base | i));
         end
      end
      rd_idx = 0;
      ack_idx = 0;
      wait_sum = 0;
      ws_count = 0;
      sif.commandIn = cmd;
      sif.snoopyAddress = addr;
      sif.snoopyHit = hit;
      sif.stateIn = st;
      txn_active = 1;
      lat = 0;
      forever begin
         @(negedge clock);
         lat++;
         if (sif.isInvalidated) break;
         if (lat > 400) begin
            fail_now("isInvalidated_timeout", lat);
            break;
         end
         // Inputs other than a non-NONE command must not matter once the command is taken.
         sif.commandIn = command_t'($urandom_range(1, 3));
         sif.snoopyAddress = $urandom;
         sif.snoopyHit = 1'($urandom_range(0, 1));
         sif.stateIn = state_t'($urandom_range(0, 2));
         if (reset_word >= 0 && sif.readEnabled && sif.readAddress[3:0] == 4'(reset_word)) begin
            #2 reset = 1'b1;
            #1 check_all_zero("async_reset");
            exp_addr_q.delete();
            exp_data_q.delete();
            txn_active = 0;
            model_err = 0;
            sif.commandIn = NONE;
            @(negedge clock);
            reset = 1'b0;
            check("writeState_after_reset", ws_count, 0);
            return;
         end
      end
      if (reset_word >= 0) fail_now("reset_word_not_reached", lat);
      exp_lat = !exp_ws ? 2 : (flush ? 3 + 32 + wait_sum : 3);
      check("latency", lat, exp_lat);
      check("reads_outstanding", exp_addr_q.size(), 0);
      check("flushes_outstanding", exp_data_q.size(), 0);
      check("writeState_pulses", ws_count, exp_ws);
      if (new_err) model_err = 1;
      check("protocolError_at_done", sif.protocolError, model_err);
      sif.commandIn = NONE;
      sif.snoopyAddress = $urandom;
      @(negedge clock);
      check("isInvalidated_drop", sif.isInvalidated, 1'b0);
      txn_active = 0;
   endtask

   initial begin : main
      int lat;
      n_checks = 0;
      n_fail = 0;
      model_err = 0;
      txn_active = 0;
      data_idx_mode = 0;
      ws_count = 0;
      last_ws_state = INVALID;
      reset = 1'b1;
      sif.commandIn = NONE;
      sif.snoopyAddress = '0;
      sif.snoopyHit = 1'b0;
      sif.stateIn = INVALID;
      repeat (2) @(negedge clock);
      check_all_zero("reset_state");
      reset = 1'b0;
      @(negedge clock);

      run_txn(BUS_READ, 32'h0000_1230, 1'b0, MODIFIED, 0, -1, -1, lat);
      check("miss_latency_lit", lat, 2);
      check("miss_no_flush_lit", obs_data.size(), 0);

      run_txn(BUS_INVALIDATE, 32'h0000_2000, 1'b1, SHARED, 0, -1, -1, lat);
      check("shared_inv_latency_lit", lat, 3);
      check("shared_inv_state_lit", last_ws_state, INVALID);

      data_idx_mode = 1;
      run_txn(BUS_READ, 32'h0000_1235, 1'b1, MODIFIED, 0, -1, -1, lat);
      check("flush_latency_lit", lat, 35);
      check("flush_word_count_lit", obs_addr.size(), 16);
      check("flush_data_count_lit", obs_data.size(), 16);
      if (obs_addr.size() == 16 && obs_data.size() == 16) begin
         check("flush_first_addr_lit", obs_addr[0], 32'h0000_1230);
         check("flush_last_addr_lit", obs_addr[15], 32'h0000_123F);
         for (int i = 0; i < 16; i++) check("flush_word_lit", obs_data[i], i);
      end
      check("flush_read_state_lit", last_ws_state, SHARED);

      run_txn(BUS_READ_EXCLUSIVE, 32'h0000_7788, 1'b1, MODIFIED, 0, 7, -1, lat);
      check("slow_ack_latency_lit", lat, 38);
      check("slow_ack_word_count_lit", obs_data.size(), 16);
      if (obs_data.size() == 16) check("slow_ack_word7_lit", obs_data[7], 7);
      check("rdx_state_lit", last_ws_state, INVALID);
      data_idx_mode = 0;

      run_txn(BUS_READ, 32'h0000_4560, 1'b1, MODIFIED, 0, -1, 9, lat);
      run_txn(BUS_READ_EXCLUSIVE, 32'h0000_4560, 1'b1, MODIFIED, 1, -1, -1, lat);
      check("post_reset_word_count_lit", obs_data.size(), 16);

      run_txn(BUS_INVALIDATE, 32'h0000_9990, 1'b1, MODIFIED, 0, -1, -1, lat);
      check("illegal_inv_error_lit", sif.protocolError, 1'b1);
      check("illegal_inv_latency_lit", lat, 3);
      check("illegal_inv_no_flush_lit", obs_data.size(), 0);
      check("illegal_inv_state_lit", last_ws_state, INVALID);

      for (int t = 0; t < 40; t++) begin
         run_txn(command_t'($urandom_range(1, 3)), $urandom, 1'($urandom_range(0, 1)),
                 state_t'($urandom_range(0, 2)), 2, -1, -1, lat);
         repeat ($urandom_range(0, 2)) @(negedge clock);
      end
      check("error_still_set_lit", sif.protocolError, 1'b1);

      reset = 1'b1;
      @(negedge clock);
      check("error_cleared_by_reset", sif.protocolError, 1'b0);
      model_err = 0;
      reset = 1'b0;
      @(negedge clock);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
